// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Fixed 33-cycle latency (32 iterations + 1 sign-fix cycle); busy stalls dependent instructions.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_FIX} state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_ma;
  logic [WIDTH-1:0]   r_mb;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;

  // Multiply walks the multiplier MSB-first: acc = 2*acc + (bit ? |a| : 0).
  logic [2*WIDTH-1:0] w_mul_next;
  assign w_mul_next = {r_acc[2*WIDTH-2:0], 1'b0}
                    + {{WIDTH{1'b0}}, (r_mb[r_cnt] ? r_ma : {WIDTH{1'b0}})};

  // Divide keeps the partial remainder in the upper half and shifts quotient bits into the lower half.
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [2*WIDTH-1:0] w_div_next;
  assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_ma[r_cnt]};
  assign w_ge       = (w_shift >= {1'b0, r_mb});
  assign w_sub      = w_shift[WIDTH-1:0] - r_mb;
  assign w_div_next = {(w_ge ? w_sub : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH-1:0]   w_lo;
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_q    = r_acc[WIDTH-1:0];
  assign w_r    = r_acc[2*WIDTH-1:WIDTH];
  // A zero divisor yields an all-ones quotient; the remainder already equals |a|, so sign-fixing restores a.
  assign w_hi   = r_div ? (r_neg_r ? -w_r : w_r) : w_prod[2*WIDTH-1:WIDTH];
  assign w_lo   = r_div ? ((r_mb == '0) ? {WIDTH{1'b1}} : (r_neg_q ? -w_q : w_q))
                        : w_prod[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush && r_state != S_IDLE) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (!flush) begin
                r_ma    <= (op[0] && a[WIDTH-1]) ? -a : a;
                r_mb    <= (op[0] && b[WIDTH-1]) ? -b : b;
                r_div   <= op[1];
                r_neg_q <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg_r <= op[0] & a[WIDTH-1];
                r_acc   <= '0;
                r_cnt   <= CW'(WIDTH - 1);
                r_state <= S_COMPUTE;
                r_busy  <= 1'b1;
              end
            end else begin
              if (mthi) r_hi <= wdata;
              if (mtlo) r_lo <= wdata;
            end
          end
          S_COMPUTE: begin
            r_acc <= r_div ? w_div_next : w_mul_next;
            if (r_cnt == '0) r_state <= S_FIX;
            else             r_cnt   <= r_cnt - 1'b1;
          end
          S_FIX: begin
            r_hi    <= w_hi;
            r_lo    <= w_lo;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: each step drives inputs after an edge and checks outputs 1ns later.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo, flush;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_err    = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one op and follow it to completion; poke > 0 injects a start+mtlo during that busy cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo, input int poke);
    int nb;
    bit dbad;
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    nb = 0;
    dbad = 1'b0;
    while (busy === 1'b1 && nb < 40) begin
      nb++;
      if (done !== 1'b0) dbad = 1'b1;
      if (nb == poke) begin
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5; mtlo = 1'b1; wdata = 32'h1111;
      end
      tick();
      start = 1'b0; mtlo = 1'b0;
    end
    check({tag, " busy_cycles"}, nb, 33);
    check({tag, " done_in_busy"}, dbad, 0);
    check({tag, " done"}, done, 1);
    check({tag, " hi"}, hi, ehi);
    check({tag, " lo"}, lo, elo);
    tick();
    check({tag, " done_drop"}, done, 0);
  endtask

  initial begin
    bit seen_done;
    reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    tick(); tick();
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst hi", hi, 0);
    check("rst lo", lo, 0);
    reset = 1'b1;
    tick();

    run_op("mult -3*7",   2'b01, 32'hFFFFFFFD, 32'd7,       32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    run_op("multu ff*ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    run_op("mult -1*-1",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0);
    run_op("div -7/2",    2'b11, 32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("divu 100/7",  2'b10, 32'd100,      32'd7,       32'd2,        32'd14,       10);
    run_op("divu by0",    2'b10, 32'h1234,     32'd0,       32'h1234,     32'hFFFFFFFF, 0);
    run_op("div -9/0",    2'b11, 32'hFFFFFFF7, 32'd0,       32'hFFFFFFF7, 32'hFFFFFFFF, 0);
    run_op("div ovf",     2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);

    // Simultaneous MTHI and MTLO both take wdata.
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A0F0F;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("mthilo hi", hi, 32'h5A5A0F0F);
    check("mthilo lo", lo, 32'h5A5A0F0F);

    mthi = 1'b1; wdata = 32'hAAAA5555;
    tick();
    mthi = 1'b0;
    check("mthi hi", hi, 32'hAAAA5555);
    check("mthi lo", lo, 32'h5A5A0F0F);

    // Launch DIV, poke start+mtlo at cycle 10, flush at cycle 20.
    op = 2'b11; a = 32'd50; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9; mtlo = 1'b1; wdata = 32'h2222;
    tick();
    start = 1'b0; mtlo = 1'b0;
    check("busy poke busy", busy, 1);
    check("busy poke lo", lo, 32'h5A5A0F0F);
    repeat (9) tick();
    check("pre flush busy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", busy, 0);
    check("flush done", done, 0);
    seen_done = 1'b0;
    repeat (20) begin
      tick();
      if (done !== 1'b0) seen_done = 1'b1;
    end
    check("flush no done", seen_done, 0);
    check("flush hi", hi, 32'hAAAA5555);
    check("flush lo", lo, 32'h5A5A0F0F);

    // Start with flush while idle must not launch.
    op = 2'b00; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush+start busy", busy, 0);

    // Reset at cycle 15 of a MULT.
    op = 2'b01; a = 32'd1234; b = 32'd5678; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    reset = 1'b0;
    tick();
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst hi", hi, 0);
    check("midrst lo", lo, 0);
    reset = 1'b1;
    tick();
    run_op("multu 3*5", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
